// File: rtl/alu_result_stage_if.sv
// Handshake bundles around the ALU result stage: ALU-side input bus and writeback-side output bus.
// master drives valid and payload, slave drives ready.
interface alu_res_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] alu_out;
  logic              S;
  logic              Z;
  logic              C;
  logic              V;

  modport master (
    output in_valid, opcode, dest, alu_out, S, Z, C, V,
    input  in_ready
  );
  modport slave (
    input  in_valid, opcode, dest, alu_out, S, Z, C, V,
    output in_ready
  );
endinterface

interface wb_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              wb_valid;
  logic              wb_ready;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output wb_valid, wb_we, wb_addr, wb_data,
    input  wb_ready
  );
  modport slave (
    input  wb_valid, wb_we, wb_addr, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result register + flag register + branch eval; result on wb_* one edge after accept, stalls hold wb_*.
// ALU_RESULT_STAGE_SKID_EN adds a second skid entry and makes in_ready registered (skid entry empty).
module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_res_if.slave   in_bus,
  wb_if.master       wb_bus,
  output logic [3:0] flags,
  input  logic [2:0] br_cond,
  output logic       br_taken
);

  logic              in_ready;
  logic              accept;
  logic              drain;
  logic              op_we;
  logic              op_flags;

  logic              wb_valid_q;
  logic              wb_we_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  assign accept = in_bus.in_valid & in_ready;
  assign drain  = wb_valid_q & wb_bus.wb_ready;

  // Compares and shifts set flags; CMP is the one flag-setter that does not write back.
  always_comb begin
    op_flags = 1'b0;
    op_we    = 1'b0;
    case (in_bus.opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: begin
        op_flags = 1'b1;
        op_we    = 1'b1;
      end
      4'b0101: op_flags = 1'b1;
      4'b0110: op_we    = 1'b1;
      4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
        op_flags = 1'b1;
        op_we    = 1'b1;
      end
      default: begin
        op_flags = 1'b0;
        op_we    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (accept && op_flags) begin
      flags <= {in_bus.S, in_bus.Z, in_bus.C, in_bus.V};
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      3'b000:  br_taken = flags[2];
      3'b001:  br_taken = flags[3] ^ flags[0];
      3'b010:  br_taken = flags[2] | (flags[3] ^ flags[0]);
      3'b011:  br_taken = ~flags[2];
      3'b100:  br_taken = flags[1];
      3'b101:  br_taken = flags[3];
      3'b110:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

`ifdef ALU_RESULT_STAGE_SKID_EN
  logic              sk_valid;
  logic              sk_we;
  logic [REG_AW-1:0] sk_addr;
  logic [DATA_W-1:0] sk_data;

  // sk_valid is a flop, so in_ready carries no combinational path from wb_ready.
  assign in_ready = ~sk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      sk_valid   <= 1'b0;
      sk_we      <= 1'b0;
      sk_addr    <= '0;
      sk_data    <= '0;
    end else if (drain) begin
      if (sk_valid) begin
        wb_we_q   <= sk_we;
        wb_addr_q <= sk_addr;
        wb_data_q <= sk_data;
        sk_valid  <= 1'b0;
      end else if (accept) begin
        wb_we_q   <= op_we;
        wb_addr_q <= in_bus.dest;
        wb_data_q <= in_bus.alu_out;
      end else begin
        wb_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (wb_valid_q) begin
        sk_valid <= 1'b1;
        sk_we    <= op_we;
        sk_addr  <= in_bus.dest;
        sk_data  <= in_bus.alu_out;
      end else begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= op_we;
        wb_addr_q  <= in_bus.dest;
        wb_data_q  <= in_bus.alu_out;
      end
    end
  end
`else
  assign in_ready = ~wb_valid_q | wb_bus.wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else if (accept) begin
      wb_valid_q <= 1'b1;
      wb_we_q    <= op_we;
      wb_addr_q  <= in_bus.dest;
      wb_data_q  <= in_bus.alu_out;
    end else if (drain) begin
      wb_valid_q <= 1'b0;
    end
  end
`endif

  assign in_bus.in_ready = in_ready;
  assign wb_bus.wb_valid = wb_valid_q;
  assign wb_bus.wb_we    = wb_we_q;
  assign wb_bus.wb_addr  = wb_addr_q;
  assign wb_bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed plan steps plus random traffic against a queue/flag reference model.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] flags;
  logic [2:0] br_cond = 3'b000;
  logic       br_taken;

  int tests = 0;
  int fails = 0;

`ifdef ALU_RESULT_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
  } ent_t;

  ent_t       q[$];
  logic [3:0] flags_m = 4'b0000;

  alu_res_if #(.DATA_W(16), .REG_AW(3)) in_bus ();
  wb_if      #(.DATA_W(16), .REG_AW(3)) wb_bus ();

  alu_result_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_bus   (in_bus),
    .wb_bus   (wb_bus),
    .flags    (flags),
    .br_cond  (br_cond),
    .br_taken (br_taken)
  );

  always #5 clk = ~clk;

  function automatic logic br_model(input logic [2:0] bc, input logic [3:0] f);
    logic s, z, c, v;
    {s, z, c, v} = f;
    case (bc)
      3'd0: return z;
      3'd1: return s != v;
      3'd2: return z || (s != v);
      3'd3: return !z;
      3'd4: return c;
      3'd5: return s;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    logic exp_rdy;
    exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || wb_bus.wb_ready);
    chk("wb_valid", 32'(wb_bus.wb_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_bus.in_ready), 32'(exp_rdy));
    chk("flags", 32'(flags), 32'(flags_m));
    chk("br_taken", 32'(br_taken), 32'(br_model(br_cond, flags_m)));
    if (q.size() > 0) begin
      chk("wb_we", 32'(wb_bus.wb_we), 32'(q[0].we));
      chk("wb_addr", 32'(wb_bus.wb_addr), 32'(q[0].addr));
      chk("wb_data", 32'(wb_bus.wb_data), 32'(q[0].data));
    end
  endtask

  // One clock: drive at negedge, check mid-low phase, update model at posedge, return at next negedge.
  task automatic step(input logic iv, input logic [3:0] op, input logic [2:0] d,
                      input logic [15:0] data, input logic [3:0] szcv,
                      input logic wr, input logic [2:0] bc, output logic acc);
    logic drn;
    ent_t e;
    in_bus.in_valid = iv;
    in_bus.opcode   = op;
    in_bus.dest     = d;
    in_bus.alu_out  = data;
    {in_bus.S, in_bus.Z, in_bus.C, in_bus.V} = szcv;
    wb_bus.wb_ready = wr;
    br_cond         = bc;
    #1;
    chk_outputs();
    acc = iv && ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || wr));
    drn = (q.size() > 0) && wr;
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) begin
      e.we   = (op <= 4'd4) || (op == 4'd6) || (op >= 4'd8 && op <= 4'd11);
      e.addr = d;
      e.data = data;
      q.push_back(e);
      if ((op <= 4'd5) || (op >= 4'd8 && op <= 4'd11)) flags_m = szcv;
    end
    @(negedge clk);
  endtask

  initial begin
    logic        acc;
    logic [15:0] bp_data[3];
    int          bp_idx;
    logic        r_iv;
    logic [3:0]  r_op;
    logic [2:0]  r_d;
    logic [15:0] r_data;
    logic [3:0]  r_f;

    in_bus.in_valid = 1'b0;
    in_bus.opcode   = 4'd0;
    in_bus.dest     = 3'd0;
    in_bus.alu_out  = 16'd0;
    {in_bus.S, in_bus.Z, in_bus.C, in_bus.V} = 4'b0000;
    wb_bus.wb_ready = 1'b0;

    // Reset state
    br_cond = 3'b011;
    #1;
    chk("rst_wb_valid", 32'(wb_bus.wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_bus.wb_we), 32'd0);
    chk("rst_wb_addr", 32'(wb_bus.wb_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_bus.wb_data), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_bus.in_ready), 32'd1);
    chk("rst_br_ne", 32'(br_taken), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD
    step(1'b1, 4'b0000, 3'd3, 16'h1234, 4'b0010, 1'b1, 3'b100, acc);
    chk("add_wb_data", 32'(wb_bus.wb_data), 32'h1234);
    chk("add_wb_addr", 32'(wb_bus.wb_addr), 32'd3);
    chk("add_wb_we", 32'(wb_bus.wb_we), 32'd1);
    chk("add_flags", 32'(flags), 32'b0010);
    br_cond = 3'b100;
    #1 chk("add_br_cs", 32'(br_taken), 32'd1);

    // CMP equal
    step(1'b1, 4'b0101, 3'd1, 16'h0000, 4'b0100, 1'b1, 3'b000, acc);
    chk("cmp_wb_we", 32'(wb_bus.wb_we), 32'd0);
    chk("cmp_flags", 32'(flags), 32'b0100);
    br_cond = 3'b000;
    #1 chk("cmp_br_eq", 32'(br_taken), 32'd1);
    br_cond = 3'b011;
    #1 chk("cmp_br_ne", 32'(br_taken), 32'd0);

    // SUB then MOV: MOV must not touch flags
    step(1'b1, 4'b0001, 3'd2, 16'hFFFE, 4'b1000, 1'b1, 3'b001, acc);
    step(1'b1, 4'b0110, 3'd5, 16'h00AA, 4'b0111, 1'b1, 3'b001, acc);
    chk("mov_flags", 32'(flags), 32'b1000);
    chk("mov_wb_we", 32'(wb_bus.wb_we), 32'd1);
    br_cond = 3'b001;
    #1 chk("mov_br_lt", 32'(br_taken), 32'd1);
    step(1'b0, 4'b0000, 3'd0, 16'h0000, 4'b0000, 1'b1, 3'b010, acc);

    // Backpressure: three queued inputs held by producer until accepted
    bp_data[0] = 16'hA001;
    bp_data[1] = 16'hA002;
    bp_data[2] = 16'hA003;
    bp_idx = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0010, 3'(bp_idx + 4), bp_data[bp_idx], 4'b0001, 1'b0, 3'b110, acc);
      if (acc) bp_idx++;
    end
    #1;
    chk("bp_in_ready", 32'(in_bus.in_ready), 32'd0);
    chk("bp_held", 32'(bp_idx), 32'(CAP));
    chk("bp_head", 32'(wb_bus.wb_data), 32'hA001);
    for (int i = 0; i < 8 && (bp_idx < 3 || q.size() > 0); i++) begin
      if (bp_idx < 3) begin
        step(1'b1, 4'b0010, 3'(bp_idx + 4), bp_data[bp_idx], 4'b0001, 1'b1, 3'b101, acc);
        if (acc) bp_idx++;
      end else begin
        step(1'b0, 4'b0000, 3'd0, 16'h0, 4'b0000, 1'b1, 3'b101, acc);
      end
    end
    chk("bp_all_sent", 32'(bp_idx), 32'd3);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Full throughput
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'(8 + (i % 4)), 3'(i), 16'(16'h5000 + i), 4'(i), 1'b1, 3'(i), acc);
      chk("tp_accept", 32'(acc), 32'd1);
    end
    step(1'b0, 4'b0000, 3'd0, 16'h0, 4'b0000, 1'b1, 3'b000, acc);

    // Reset mid-stall
    step(1'b1, 4'b0000, 3'd6, 16'hDEAD, 4'b1111, 1'b0, 3'b000, acc);
    step(1'b0, 4'b0000, 3'd0, 16'h0, 4'b0000, 1'b0, 3'b000, acc);
    in_bus.in_valid = 1'b0;
    br_cond = 3'b011;
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_wb_valid", 32'(wb_bus.wb_valid), 32'd0);
    chk("mrst_flags", 32'(flags), 32'd0);
    chk("mrst_in_ready", 32'(in_bus.in_ready), 32'd1);
    chk("mrst_br_ne", 32'(br_taken), 32'd1);
    q.delete();
    flags_m = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b0000, 3'd0, 16'h0, 4'b0000, 1'b1, 3'(i), acc);

    // Random traffic; an offer not yet accepted is held unchanged
    r_iv = 1'b0;
    r_op = 4'd0; r_d = 3'd0; r_data = 16'd0; r_f = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if (!r_iv) begin
        r_iv   = ($urandom_range(0, 9) < 7);
        r_op   = 4'($urandom_range(0, 15));
        r_d    = 3'($urandom_range(0, 7));
        r_data = 16'($urandom);
        r_f    = 4'($urandom_range(0, 15));
      end
      step(r_iv, r_op, r_d, r_data, r_f, 1'($urandom_range(0, 9) < 6),
           3'($urandom_range(0, 7)), acc);
      if (acc) r_iv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
